// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg
// Shared constants for the data-memory bus arbiter:
//   - address map window bounds (DM, TC1, TC2, interrupt controller)
//   - bus owner state encoding used by the arbiter's state register
//   - an address-window membership helper
package dm_bus_arbiter_pkg;

    // Address map of the data-side bus.
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC1_TOP  = 32'h0000_7F0B;
    localparam logic [31:0] TC2_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC2_TOP  = 32'h0000_7F1B;
    localparam logic [31:0] INT_BASE = 32'h0000_7F20;
    localparam logic [31:0] INT_TOP  = 32'h0000_7F23;

    // Who was granted the bus in the previous cycle.
    typedef enum logic [1:0] {
        OWN_IDLE       = 2'd0,
        OWN_CPU        = 2'd1,
        OWN_DMA        = 2'd2,
        OWN_DMA_LOCKED = 2'd3
    } owner_t;

    // Inclusive window test done as one unsigned compare: an address below
    // lo wraps around to a huge offset and so also lands outside the window.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr - lo) <= (hi - lo);
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_arb_pick.sv
// dm_bus_arbiter_arb_pick (arb_pick)
// Combinational two-requester round-robin picker with a lock override.
// Ports:
//   req_cpu, req_dma : valid requests this cycle
//   lock_hold        : DMA holds a locked burst that has not used up its quota
//   last_cpu         : the previous grant went to the CPU
//   gnt[1:0]         : one-hot grant, bit 0 = CPU, bit 1 = DMA
module dm_bus_arbiter_arb_pick (
    input  logic       req_cpu,
    input  logic       req_dma,
    input  logic       lock_hold,
    input  logic       last_cpu,
    output logic [1:0] gnt
);

    // On contention the DMA wins only while its lock is honoured or when the
    // CPU had the bus last; an idle or DMA history hands the slot to the CPU.
    always_comb begin
        gnt = 2'b00;
        if (req_cpu && req_dma) begin
            if (lock_hold || last_cpu) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else if (req_cpu) begin
            gnt = 2'b01;
        end else if (req_dma) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter
// Shares the data-memory/peripheral bus between the CPU M-stage port and a
// DMA block-copy requester. At most one access per cycle; grant, bus drive and
// CPU read data are all in the request cycle. DMA is confined to the DM window
// and its locked bursts are capped at MAX_BURST while the CPU waits.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_req/addr/wdata/byteen  : CPU access (byteen 0 = read)
//   cpu_rdata, cpu_stall       : CPU read data and pipeline freeze
//   dma_req/lock/addr/wdata/byteen : DMA access and burst lock request
//   dma_gnt                    : DMA access performed this cycle
//   dma_rdata, dma_rvalid      : DMA read data, one cycle after the grant
//   dma_err                    : pulse one cycle after an out-of-window request
//   bus_addr/wdata/byteen/rdata: bridge side
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int          MAX_BURST = 8,
    parameter int          BURST_W   = 4,
    parameter logic [31:0] DM_START  = 32'h0000_0000,
    parameter logic [31:0] DM_END    = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    owner_t             owner;
    logic [BURST_W-1:0] bcnt;
    logic               dma_ok;
    logic               cpu_gnt;
    logic               lock_hold;
    logic               last_cpu;
    logic [1:0]         gnt;

    // An out-of-window DMA request is treated as no request at all.
    assign dma_ok    = dma_req & in_window(dma_addr, DM_START, DM_END);
    assign lock_hold = (owner == OWN_DMA_LOCKED) && (bcnt < BURST_MAX);
    assign last_cpu  = (owner == OWN_CPU);

    dm_bus_arbiter_arb_pick u_pick (
        .req_cpu   (cpu_req),
        .req_dma   (dma_ok),
        .lock_hold (lock_hold),
        .last_cpu  (last_cpu),
        .gnt       (gnt)
    );

    assign cpu_gnt   = gnt[0];
    assign dma_gnt   = gnt[1];
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign cpu_rdata = bus_rdata;

    // Bus mux. With no grant the bus sees a harmless read at the CPU address.
    always_comb begin
        bus_addr   = cpu_addr;
        bus_wdata  = 32'h0;
        bus_byteen = 4'h0;
        if (cpu_gnt) begin
            bus_wdata  = cpu_wdata;
            bus_byteen = cpu_byteen;
        end else if (dma_gnt) begin
            bus_addr   = dma_addr;
            bus_wdata  = dma_wdata;
            bus_byteen = dma_byteen;
        end
    end

    // Owner state, burst counter and registered DMA responses. The burst count
    // only survives consecutive locked DMA grants and saturates at the cap so a
    // lone DMA can keep the bus, while a waiting CPU is let in at the cap.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_IDLE;
            bcnt       <= '0;
            dma_rvalid <= 1'b0;
            dma_err    <= 1'b0;
            dma_rdata  <= 32'h0;
        end else begin
            dma_err    <= dma_req & ~dma_ok;
            dma_rvalid <= dma_gnt & (dma_byteen == 4'h0);
            if (dma_gnt && (dma_byteen == 4'h0)) begin
                dma_rdata <= bus_rdata;
            end
            if (cpu_gnt) begin
                owner <= OWN_CPU;
            end else if (dma_gnt) begin
                owner <= dma_lock ? OWN_DMA_LOCKED : OWN_DMA;
            end else begin
                owner <= OWN_IDLE;
            end
            if (dma_gnt && dma_lock) begin
                if (bcnt != BURST_MAX) begin
                    bcnt <= bcnt + 1'b1;
                end
            end else begin
                bcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter
// Self-checking bench for dm_bus_arbiter (MAX_BURST = 4). A small memory
// behind the bus and a behavioural model of the arbitration rules produce
// every expected value; directed scenarios are followed by a random run.
module tb_dm_bus_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_lock;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_byteen;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        dma_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_rdata;

    logic [31:0] mem [0:4095];
    logic        tc1_written;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: last grant (0 none, 1 cpu, 2 dma), whether that DMA grant
    // asked to lock, length of the current locked run, and registered outputs.
    int          m_last;
    bit          m_locked;
    int          m_run;
    logic        m_rvalid;
    logic        m_err;
    logic [31:0] m_rdata;
    int          n_last;
    bit          n_locked;
    int          n_run;
    logic        n_rvalid;
    logic        n_err;
    logic [31:0] n_rdata;
    logic        exp_cpu_gnt;
    logic [101:0] exp_comb;

    wire [101:0] comb_obs = {cpu_stall, dma_gnt, bus_addr, bus_wdata, bus_byteen, cpu_rdata};
    wire [33:0]  reg_obs  = {dma_rvalid, dma_err, dma_rdata};
    wire [33:0]  reg_exp  = {m_rvalid, m_err, m_rdata};

    dm_bus_arbiter #(
        .MAX_BURST (MAXB),
        .BURST_W   (4),
        .DM_START  (32'h0000_0000),
        .DM_END    (32'h0000_2FFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_lock   (dma_lock),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_byteen (dma_byteen),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_err    (dma_err),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen),
        .bus_rdata  (bus_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Bridge stand-in: word memory read combinationally, written at the edge;
    // writes landing in the TC1 window are flagged.
    assign bus_rdata = mem[bus_addr[13:2]];

    always @(posedge clk) begin
        if (bus_byteen != 4'h0) begin
            mem[bus_addr[13:2]] <= bus_wdata;
            if (bus_addr >= 32'h7F00 && bus_addr <= 32'h7F0B) tc1_written <= 1'b1;
        end
    end

    // Apply the arbitration rules to the current inputs and model state.
    task automatic model_eval();
        bit cv, dv, cg, dg;
        logic [31:0] ba, bw;
        logic [3:0]  bb;
        cv = cpu_req;
        dv = dma_req && (dma_addr <= 32'h2FFF);
        cg = 0;
        dg = 0;
        if (cv && dv) begin
            if (m_locked && m_run < MAXB) dg = 1;
            else if (m_last == 1) dg = 1;
            else cg = 1;
        end else if (cv) cg = 1;
        else if (dv) dg = 1;
        if (cg) begin ba = cpu_addr; bw = cpu_wdata; bb = cpu_byteen; end
        else if (dg) begin ba = dma_addr; bw = dma_wdata; bb = dma_byteen; end
        else begin ba = cpu_addr; bw = 32'h0; bb = 4'h0; end
        exp_cpu_gnt = cg;
        exp_comb = {cv && !cg, dg, ba, bw, bb, mem[ba[13:2]]};
        n_rvalid = dg && (dma_byteen == 4'h0);
        n_rdata  = n_rvalid ? mem[dma_addr[13:2]] : m_rdata;
        n_err    = dma_req && !dv;
        n_last   = cg ? 1 : (dg ? 2 : 0);
        if (dg && dma_lock) begin
            n_locked = 1;
            n_run    = (m_run < MAXB) ? m_run + 1 : MAXB;
        end else begin
            n_locked = 0;
            n_run    = 0;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            m_last = 0; m_locked = 0; m_run = 0;
            m_rvalid = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
        end else begin
            m_last = n_last; m_locked = n_locked; m_run = n_run;
            m_rvalid = n_rvalid; m_err = n_err; m_rdata = n_rdata;
        end
    endtask

    task automatic drive(input logic cr, input logic [31:0] ca, input logic [31:0] cw,
                         input logic [3:0] cb, input logic dr, input logic dl,
                         input logic [31:0] da, input logic [31:0] dw, input logic [3:0] db);
        cpu_req = cr; cpu_addr = ca; cpu_wdata = cw; cpu_byteen = cb;
        dma_req = dr; dma_lock = dl; dma_addr = da; dma_wdata = dw; dma_byteen = db;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 32'h44, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            model_eval();
            @(negedge clk);
            vectors++;
            if (comb_obs !== exp_comb) begin
                miscompares++;
                $display("[TB] FAIL reset_comb cyc%0d got=%h exp=%h", i, comb_obs, exp_comb);
            end
            @(posedge clk);
            model_commit();
            #1;
            vectors++;
            if (reg_obs !== 34'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_regs cyc%0d got=%h exp=0", i, reg_obs);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_cpu_only();
        pulse_reset();
        drive(1, 32'h0010, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        model_eval();
        @(negedge clk);
        vectors++;
        if ({cpu_stall, dma_gnt, bus_addr, cpu_rdata} !== {1'b0, 1'b0, 32'h0010, mem[4]}) begin
            miscompares++;
            $display("[TB] FAIL cpu_only got=%h exp=%h", {cpu_stall, dma_gnt, bus_addr, cpu_rdata},
                     {1'b0, 1'b0, 32'h0010, mem[4]});
        end
        @(posedge clk);
        model_commit();
        #1;
        vectors++;
        if (reg_obs !== reg_exp) begin
            miscompares++;
            $display("[TB] FAIL cpu_only_regs got=%h exp=%h", reg_obs, reg_exp);
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        drive(1, 32'h0020, 32'h0, 4'h0, 1, 0, 32'h0200, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            model_eval();
            @(negedge clk);
            vectors++;
            if ({cpu_stall, dma_gnt} !== {i[0], i[0]} || comb_obs !== exp_comb) begin
                miscompares++;
                $display("[TB] FAIL round_robin cyc%0d got=%h exp=%h", i, comb_obs, exp_comb);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
    endtask

    task automatic test_locked_burst();
        logic [5:0] seen;
        pulse_reset();
        drive(0, 32'h0030, 32'h0, 4'h0, 1, 1, 32'h0400, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) cpu_req = 1'b1;
            dma_addr = 32'h0400 + 32'(i * 4);
            model_eval();
            @(negedge clk);
            seen[i] = dma_gnt;
            vectors++;
            if (comb_obs !== exp_comb) begin
                miscompares++;
                $display("[TB] FAIL locked_comb cyc%0d got=%h exp=%h", i, comb_obs, exp_comb);
            end
            @(posedge clk);
            model_commit();
            #1;
            vectors++;
            if (reg_obs !== reg_exp) begin
                miscompares++;
                $display("[TB] FAIL locked_regs cyc%0d got=%h exp=%h", i, reg_obs, reg_exp);
            end
        end
        vectors++;
        if (seen !== 6'b101111) begin
            miscompares++;
            $display("[TB] FAIL locked_pattern got=%b exp=101111", seen);
        end
    endtask

    task automatic test_dma_read();
        pulse_reset();
        drive(0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0100, 32'h0, 4'h0);
        model_eval();
        @(negedge clk);
        vectors++;
        if (dma_gnt !== 1'b1 || bus_addr !== 32'h0100) begin
            miscompares++;
            $display("[TB] FAIL dma_read_gnt got=%b/%h exp=1/00000100", dma_gnt, bus_addr);
        end
        @(posedge clk);
        model_commit();
        #1;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if ({dma_rvalid, dma_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            miscompares++;
            $display("[TB] FAIL dma_read_data got=%h exp=1deadbeef", {dma_rvalid, dma_rdata});
        end
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
        vectors++;
        if (dma_rvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dma_rvalid_pulse got=%b exp=0", dma_rvalid);
        end
    endtask

    task automatic test_reject();
        drive(1, 32'h0024, 32'h0, 4'h0, 1, 0, 32'h7F00, 32'h1234_5678, 4'hF);
        model_eval();
        @(negedge clk);
        vectors++;
        if ({dma_gnt, cpu_stall, bus_addr, bus_byteen} !== {1'b0, 1'b0, 32'h0024, 4'h0}) begin
            miscompares++;
            $display("[TB] FAIL reject_gnt got=%h exp=%h", {dma_gnt, cpu_stall, bus_addr, bus_byteen},
                     {1'b0, 1'b0, 32'h0024, 4'h0});
        end
        @(posedge clk);
        model_commit();
        #1;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if (dma_err !== 1'b1 || tc1_written !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reject_err got=%b tc1=%b exp=1 tc1=0", dma_err, tc1_written);
        end
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset_mid_burst();
        pulse_reset();
        drive(0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h0800, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) reset = 1'b1;
            model_eval();
            @(negedge clk);
            vectors++;
            if (comb_obs !== exp_comb) begin
                miscompares++;
                $display("[TB] FAIL midburst_comb cyc%0d got=%h exp=%h", i, comb_obs, exp_comb);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
        reset = 1'b0;
        vectors++;
        if ({dma_rvalid, dma_err} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL midburst_drop got=%b exp=00", {dma_rvalid, dma_err});
        end
        drive(1, 32'h0008, 32'h0, 4'h0, 1, 1, 32'h0804, 32'h0, 4'h0);
        model_eval();
        @(negedge clk);
        vectors++;
        if ({dma_gnt, cpu_stall} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL midburst_cpu_first got=%b exp=00", {dma_gnt, cpu_stall});
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_random();
        int stall_run = 0;
        for (int i = 0; i < 400; i++) begin
            // A stalled CPU keeps its request unchanged.
            if (!(cpu_req && !exp_cpu_gnt)) begin
                cpu_req    = ($urandom_range(0, 3) != 0);
                cpu_addr   = {18'h0, 12'($urandom), 2'b00};
                cpu_wdata  = $urandom;
                cpu_byteen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            dma_req    = ($urandom_range(0, 3) != 0);
            dma_lock   = ($urandom_range(0, 2) != 0);
            dma_addr   = ($urandom_range(0, 7) == 0) ? 32'h3000 + 32'($urandom_range(0, 255)) * 4
                                                     : 32'($urandom_range(0, 32'h2FFF)) & ~32'h3;
            dma_wdata  = $urandom;
            dma_byteen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            model_eval();
            @(negedge clk);
            stall_run = cpu_stall ? stall_run + 1 : 0;
            vectors++;
            if (comb_obs !== exp_comb) begin
                miscompares++;
                $display("[TB] FAIL random_comb cyc%0d got=%h exp=%h", i, comb_obs, exp_comb);
            end
            vectors++;
            if (stall_run > MAXB) begin
                miscompares++;
                $display("[TB] FAIL random_stall_bound cyc%0d got=%0d exp<=%0d", i, stall_run, MAXB);
            end
            @(posedge clk);
            model_commit();
            #1;
            vectors++;
            if (reg_obs !== reg_exp) begin
                miscompares++;
                $display("[TB] FAIL random_regs cyc%0d got=%h exp=%h", i, reg_obs, reg_exp);
            end
        end
    endtask

    // Test sequence.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[32'h0100 >> 2] = 32'hDEADBEEF;
        tc1_written = 1'b0;
        m_last = 0; m_locked = 0; m_run = 0;
        m_rvalid = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
        exp_cpu_gnt = 1'b0;
        reset = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        test_reset();
        test_cpu_only();
        test_round_robin();
        test_locked_burst();
        test_dma_read();
        test_reject();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
